// File: rtl/pll_lock_monitor_if.sv
`timescale 1ns/1ps
// Signal bundle between the PLL lock monitor and its environment
// (boot sequencer handshake, PLL lock, released resets and status).
interface pll_lock_monitor_if;
  logic       init_done_i;
  logic       pll_lock_i;
  logic       pll_reinit_o;
  logic       sys_rst_n_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lost_cnt_o;

  modport master (
    input  init_done_i,
    input  pll_lock_i,
    output pll_reinit_o,
    output sys_rst_n_o,
    output locked_o,
    output fail_o,
    output retry_cnt_o,
    output lost_cnt_o
  );

  modport slave (
    output init_done_i,
    output pll_lock_i,
    input  pll_reinit_o,
    input  sys_rst_n_o,
    input  locked_o,
    input  fail_o,
    input  retry_cnt_o,
    input  lost_cnt_o
  );
endinterface

// File: rtl/pll_lock_monitor.sv
`timescale 1ns/1ps
// Qualifies PLL lock over a stability window before releasing the system
// reset; retries the boot sequence on lock timeout and tracks lock losses.
module pll_lock_monitor #(
  parameter int unsigned g_stable_cycles = 100000,
  parameter int unsigned g_lock_timeout  = 10000000,
  parameter int unsigned g_max_retries   = 3,
  parameter int unsigned g_reinit_len    = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  pll_lock_monitor_if.master mon
);

  localparam logic [23:0] STABLE_LAST  = 24'(g_stable_cycles - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(g_lock_timeout - 1);
  localparam logic [23:0] REINIT_LAST  = 24'(g_reinit_len - 1);
  localparam logic [3:0]  MAX_RETRIES  = 4'(g_max_retries);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUNNING,
    S_REINIT,
    S_FAILED
  } state_e;

  state_e      state_q, state_d;
  logic        state_chg;
  logic [23:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        lock_s;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  lost_q, lost_d;
  logic        reinit_q, reinit_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lock indicator is asynchronous: two flops before anything looks at it.
  always_comb begin
    sync1_d = mon.pll_lock_i;
    sync2_d = sync1_q;
  end

  assign lock_s    = sync2_q;
  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_WAIT_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_INIT: begin
        if (mon.init_done_i && armed_q) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = (retry_q < MAX_RETRIES) ? S_REINIT : S_FAILED;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
      end
      S_REINIT: begin
        if (cnt_q == REINIT_LAST) state_d = S_WAIT_INIT;
      end
      S_FAILED: state_d = S_FAILED;
      default:  state_d = S_WAIT_INIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    cnt_d       = 24'd0;
    armed_d     = armed_q;
    retry_d     = retry_q;
    lost_d      = lost_q;
    reinit_d    = (state_d == S_REINIT);
    sys_rst_n_d = (state_d == S_RUNNING);
    locked_d    = (state_d == S_RUNNING);
    fail_d      = (state_d == S_FAILED);

    if (!state_chg) begin
      case (state_q)
        S_WAIT_LOCK, S_STABLE, S_REINIT: cnt_d = cnt_q + 24'd1;
        default:                         cnt_d = 24'd0;
      endcase
    end

    // A stale init-done held across a reinit must be seen low before it counts.
    if (state_q == S_WAIT_INIT && !mon.init_done_i) begin
      armed_d = 1'b1;
    end else if (state_q == S_REINIT) begin
      armed_d = 1'b0;
    end

    if (state_chg && state_d == S_RUNNING) begin
      retry_d = 4'd0;
    end else if (state_chg && state_d == S_REINIT) begin
      retry_d = retry_q + 4'd1;
    end

    if (state_q == S_RUNNING && state_d == S_WAIT_LOCK) begin
      lost_d = sat_inc8(lost_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= 24'd0;
      armed_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      retry_q     <= 4'd0;
      lost_q      <= 8'd0;
      reinit_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      reinit_q    <= reinit_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign mon.pll_reinit_o = reinit_q;
  assign mon.sys_rst_n_o  = sys_rst_n_q;
  assign mon.locked_o     = locked_q;
  assign mon.fail_o       = fail_q;
  assign mon.retry_cnt_o  = retry_q;
  assign mon.lost_cnt_o   = lost_q;

endmodule
